// File: rtl/sram_1w1r_param_wrapper.sv
// Single-port-write / single-port-read SRAM model with lane masking, optional
// write-to-read forwarding and optional post-reset zero clearing.
module sram_1w1r_param_wrapper #(
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned MASK_GRAN = 16,
  parameter bit          BYPASS    = 1'b1,
  parameter bit          INIT_ZERO = 1'b1,
  localparam int unsigned MASK_W   = WIDTH / MASK_GRAN,
  localparam int unsigned ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic              W0_en,
  input  logic [MASK_W-1:0] W0_mask,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [WIDTH-1:0]  R0_data,
  output logic              init_done
);

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic              cnt_last;
  logic              w_in_range;
  logic              r_in_range;
  logic              init_we;
  logic              wr_acc;
  logic              rd_acc;
  logic [WIDTH-1:0]  rd_word_c;

  logic [WIDTH-1:0]  mem [DEPTH];

  assign cnt_last   = (cnt == LAST_IDX);
  assign w_in_range = ({1'b0, W0_addr} < DEPTH_X);
  assign r_in_range = ({1'b0, R0_addr} < DEPTH_X);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT_ZERO ? ST_INIT : ST_READY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: clearing ends on the cycle that zeroes the last entry
  always_comb begin
    state_next = state;
    if ((state == ST_INIT) && cnt_last) begin
      state_next = ST_READY;
    end
  end

  // Output decode: traffic is only accepted once the array is ready
  always_comb begin
    init_we = 1'b0;
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    case (state)
      ST_INIT:  init_we = 1'b1;
      ST_READY: begin
        wr_acc = W0_en && w_in_range;
        rd_acc = R0_en;
      end
      default: ;
    endcase
  end

  // Clear counter; parks on the last entry so it never leaves the array
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (init_we && !cnt_last) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      init_done <= !INIT_ZERO;
    end else begin
      init_done <= (state_next == ST_READY);
    end
  end

  // Array update: contents survive reset, but a reset edge drops any write
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (init_we) begin
        mem[cnt] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < int'(MASK_W); i++) begin
          if (W0_mask[i]) begin
            mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
          end
        end
      end
    end
  end

  // Read word with per-lane forwarding of a colliding write
  always_comb begin
    rd_word_c = '0;
    if (r_in_range) begin
      rd_word_c = mem[R0_addr];
      if (BYPASS && wr_acc && (W0_addr == R0_addr)) begin
        for (int i = 0; i < int'(MASK_W); i++) begin
          if (W0_mask[i]) begin
            rd_word_c[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      R0_data <= '0;
    end else if (rd_acc) begin
      R0_data <= rd_word_c;
    end
  end

endmodule

// File: tb/tb_sram_1w1r_param_wrapper.sv
// Directed bench for sram_1w1r_param_wrapper: a default instance (DEPTH 128,
// forwarding on) and a DEPTH 40 instance without forwarding share one stimulus.
module tb_sram_1w1r_param_wrapper;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  w_addr = '0;
  logic [6:0]  r_addr = '0;
  logic [63:0] w_data = '0;
  logic [3:0]  w_mask = '0;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic        done_a;
  logic        done_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] q_a [$];
  logic [63:0] q_b [$];
  string       q_tag [$];

  always #5 clock = ~clock;

  sram_1w1r_param_wrapper dut_a (
    .clock    (clock),
    .reset    (reset),
    .W0_addr  (w_addr),
    .W0_data  (w_data),
    .W0_en    (w_en),
    .W0_mask  (w_mask),
    .R0_addr  (r_addr),
    .R0_en    (r_en),
    .R0_data  (rd_a),
    .init_done(done_a)
  );

  sram_1w1r_param_wrapper #(
    .DEPTH (40),
    .BYPASS(1'b0)
  ) dut_b (
    .clock    (clock),
    .reset    (reset),
    .W0_addr  (w_addr[5:0]),
    .W0_data  (w_data),
    .W0_en    (w_en),
    .W0_mask  (w_mask),
    .R0_addr  (r_addr[5:0]),
    .R0_en    (r_en),
    .R0_data  (rd_b),
    .init_done(done_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of traffic; expected read data is queued now, compared after the edge
  task automatic step(input logic wen, input logic [6:0] wa, input logic [63:0] wd,
                      input logic [3:0] wm, input logic ren, input logic [6:0] ra,
                      input logic [63:0] ea, input logic [63:0] eb, input string tag);
    string t;
    w_en = wen; w_addr = wa; w_data = wd; w_mask = wm;
    r_en = ren; r_addr = ra;
    if (ren) begin
      q_a.push_back(ea);
      q_b.push_back(eb);
      q_tag.push_back(tag);
    end
    @(posedge clock); #1;
    w_en = 1'b0; r_en = 1'b0;
    if (ren) begin
      t = q_tag.pop_front();
      check({t, "_a"}, rd_a, q_a.pop_front());
      check({t, "_b"}, rd_b, q_b.pop_front());
    end
  endtask

  // Counts edges until each instance raises init_done; optionally hammers addr 3 early on
  task automatic wait_init(input logic traffic, output int ca, output int cb);
    int c;
    c = 0; ca = -1; cb = -1;
    while ((ca < 0 || cb < 0) && c < 300) begin
      if (traffic && c < 30) begin
        w_en = 1'b1; w_addr = 7'd3; w_data = '1; w_mask = 4'hF;
        r_en = 1'b1; r_addr = 7'd3;
      end else begin
        w_en = 1'b0; r_en = 1'b0;
      end
      @(posedge clock); #1;
      c++;
      if (done_a && ca < 0) ca = c;
      if (done_b && cb < 0) cb = c;
    end
    w_en = 1'b0; r_en = 1'b0;
  endtask

  initial begin
    int ca, cb;

    repeat (3) @(posedge clock);
    #1;
    check("rst_rdata_a", rd_a, 64'h0);
    check("rst_rdata_b", rd_b, 64'h0);
    check("rst_done_a", 64'(done_a), 64'h0);
    check("rst_done_b", 64'(done_b), 64'h0);

    reset = 1'b0;
    wait_init(1'b1, ca, cb);
    check("init_len_a", 64'(ca), 64'd128);
    check("init_len_b", 64'(cb), 64'd40);
    check("init_rdata_a", rd_a, 64'h0);
    check("init_rdata_b", rd_b, 64'h0);

    step(1'b0, 7'd0, '0, 4'h0, 1'b1, 7'd0,   64'h0, 64'h0, "clr_e0");
    step(1'b0, 7'd0, '0, 4'h0, 1'b1, 7'd64,  64'h0, 64'h0, "clr_e64");
    step(1'b0, 7'd0, '0, 4'h0, 1'b1, 7'd127, 64'h0, 64'h0, "clr_e127");
    step(1'b0, 7'd0, '0, 4'h0, 1'b1, 7'd3,   64'h0, 64'h0, "init_wr_ignored");

    step(1'b1, 7'd5, 64'h1111_2222_3333_4444, 4'hF, 1'b0, 7'd0, '0, '0, "");
    step(1'b1, 7'd5, 64'hAAAA_BBBB_CCCC_DDDD, 4'b0101, 1'b0, 7'd0, '0, '0, "");
    step(1'b0, 7'd0, '0, 4'h0, 1'b1, 7'd5,
         64'h1111_BBBB_3333_DDDD, 64'h1111_BBBB_3333_DDDD, "mask_merge");

    step(1'b1, 7'd9, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0011, 1'b1, 7'd9,
         64'h0000_0000_FFFF_FFFF, 64'h0, "collide");
    step(1'b0, 7'd0, '0, 4'h0, 1'b1, 7'd9,
         64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, "post_collide");
    step(1'b0, 7'd0, '0, 4'h0, 1'b0, 7'd0, '0, '0, "");
    check("hold_a", rd_a, 64'h0000_0000_FFFF_FFFF);
    check("hold_b", rd_b, 64'h0000_0000_FFFF_FFFF);
    step(1'b1, 7'd9, 64'h1234_5678_9ABC_DEF0, 4'h0, 1'b1, 7'd9,
         64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, "zero_mask");
    step(1'b0, 7'd0, '0, 4'h0, 1'b1, 7'd9,
         64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, "zero_mask_after");

    step(1'b1, 7'd39, 64'h5555_5555_5555_5555, 4'hF, 1'b0, 7'd0, '0, '0, "");
    step(1'b1, 7'd45, 64'hDEAD_BEEF_0BAD_F00D, 4'hF, 1'b0, 7'd0, '0, '0, "");
    step(1'b0, 7'd0, '0, 4'h0, 1'b1, 7'd45, 64'hDEAD_BEEF_0BAD_F00D, 64'h0, "oob_read");
    step(1'b0, 7'd0, '0, 4'h0, 1'b1, 7'd39,
         64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, "last_entry");

    step(1'b1, 7'd3, 64'h7777_7777_7777_7777, 4'hF, 1'b0, 7'd0, '0, '0, "");
    step(1'b0, 7'd0, '0, 4'h0, 1'b1, 7'd3,
         64'h7777_7777_7777_7777, 64'h7777_7777_7777_7777, "pre_reset");

    reset = 1'b1; r_en = 1'b1; r_addr = 7'd5;
    @(posedge clock); #1;
    r_en = 1'b0;
    check("mid_rst_rdata_a", rd_a, 64'h0);
    check("mid_rst_rdata_b", rd_b, 64'h0);
    check("mid_rst_done_a", 64'(done_a), 64'h0);
    check("mid_rst_done_b", 64'(done_b), 64'h0);

    reset = 1'b0;
    repeat (59) @(posedge clock);
    #1;
    check("init59_done_a", 64'(done_a), 64'h0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    wait_init(1'b0, ca, cb);
    check("reinit_len_a", 64'(ca), 64'd128);
    check("reinit_len_b", 64'(cb), 64'd40);
    step(1'b0, 7'd0, '0, 4'h0, 1'b1, 7'd3, 64'h0, 64'h0, "reinit_clear");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_1w1r_param_wrapper.md
SRAM_1W1R_PARAM_WRAPPER -- requirements
Module: sram_1w1r_param_wrapper

Interface
REQ-001 SHALL have parameter DEPTH, default 128, number of entries; any value 2..4096, non-power-of-2 allowed (e.g. 40).
REQ-002 SHALL have parameter WIDTH, default 64, data bits per entry.
REQ-003 SHALL have parameter MASK_GRAN, default 16, bits per write-mask lane; WIDTH is a multiple of MASK_GRAN; MASK_W = WIDTH/MASK_GRAN.
REQ-004 SHALL have parameter BYPASS, default 1; 1 = write-to-read forwarding on address collision, 0 = old data returned.
REQ-005 SHALL have parameter INIT_ZERO, default 1; 1 = zero all entries after reset, 0 = no clearing.
REQ-006 SHALL derive ADDR_W = max(1, clog2(DEPTH)).
REQ-007 clock  input  1  single clock for both ports; all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 W0_addr  input  ADDR_W  write address.
REQ-010 W0_data  input  WIDTH  write data.
REQ-011 W0_en  input  1  write enable, active-high.
REQ-012 W0_mask  input  MASK_W  per-lane write enable; lane i covers bits [i*MASK_GRAN +: MASK_GRAN].
REQ-013 R0_addr  input  ADDR_W  read address.
REQ-014 R0_en  input  1  read enable, active-high.
REQ-015 R0_data  output  WIDTH  read data, registered.
REQ-016 init_done  output  1  high when the array is ready for traffic.

Function
REQ-017 Storage SHALL be a DEPTH x WIDTH array; a write at edge N with W0_en=1 SHALL update only the lanes whose W0_mask bit is 1.
REQ-018 Read latency SHALL be 1 cycle: R0_en=1 at edge N, R0_data valid after edge N, stable until the next accepted read.
REQ-019 With R0_en=0, R0_data SHALL hold its previous value.
REQ-020 W0_addr >= DEPTH SHALL be ignored (no array change); R0_addr >= DEPTH SHALL return all-zero data.
REQ-021 Same-cycle read and write to the same in-range address with BYPASS=1 SHALL return, per lane, W0_data where W0_mask=1 and the prior stored value where W0_mask=0.
REQ-022 The same collision with BYPASS=0 SHALL return the prior stored value for every lane.
REQ-023 A write with W0_mask all-zero SHALL neither change the array nor forward data.
REQ-024 FSM states SHALL be INIT and READY; encoding is free.
REQ-025 With INIT_ZERO=1: reset SHALL enter INIT with counter 0; each INIT cycle SHALL write zero to entry counter, then increment; the entry DEPTH-1 cycle SHALL transition to READY; INIT lasts exactly DEPTH cycles.
REQ-026 With INIT_ZERO=0: reset SHALL enter READY directly.
REQ-027 In INIT, W0_en and R0_en SHALL be ignored (no write, R0_data unchanged at 0); init_done SHALL be 0 in INIT and 1 in READY.
REQ-028 Counter SHALL be ADDR_W bits and SHALL never address beyond DEPTH-1.

Reset
REQ-029 Reset asserted at any edge, including mid-INIT or mid-traffic, SHALL force R0_data=0, init_done=0 (INIT_ZERO=1) or 1 (INIT_ZERO=0), counter=0, state per REQ-025/026.
REQ-030 Reset SHALL cancel any same-edge write and read; with INIT_ZERO=0 array contents are not altered by reset.
REQ-031 With INIT_ZERO=1, clearing restarts from entry 0 after every reset.

Verification
REQ-032 DEPTH=128, INIT_ZERO=1: release reset -> init_done rises after exactly 128 cycles; reads of entries 0, 64, 127 return 0.
REQ-033 WIDTH=64, MASK_GRAN=16: write 0x1111_2222_3333_4444 to addr 5 full mask, then 0xAAAA_BBBB_CCCC_DDDD mask 4'b0101 -> read addr 5 returns 0x1111_BBBB_3333_DDDD one cycle later.
REQ-034 Addr 9 holds 0; same-cycle write 0xFFFF_FFFF_FFFF_FFFF mask 4'b0011 and read addr 9 -> BYPASS=1 returns 0x0000_0000_FFFF_FFFF; BYPASS=0 returns 0; next read returns 0x0000_0000_FFFF_FFFF in both.
REQ-035 DEPTH=40: write addr 45 then read addr 45 -> R0_data=0; read addr 39 unaffected.
REQ-036 Reset asserted at INIT cycle 60 after writing addr 3 pre-reset (INIT_ZERO=1) -> init_done stays 0 for 128 cycles after release; addr 3 reads 0.
REQ-037 R0_en=1 and W0_en=1 during INIT -> no array change, R0_data stays 0.
